pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 8-stage in-order core: PC, IF1, IF2, ID, EX, MEM1, MEM2, WB.
- Detects load-use hazards between the ID source registers and loads still in EX/MEM1.
- Sequences the multi-cycle iterative divider in EX.
- Converts WB trap/redirect requests into a pipeline flush.
- Drives the stall vector and flush consumed by every stage register, including the ID input register.

Parameters:
- STALL_W, 8, stall vector width; bit k holds the register feeding stage k+1 (0=PC … 7=WB).
- DIV_LAT, 34, total cycles a divide occupies EX, including its release cycle; legal range ≥ 2.
- CNT_W, 32, width of the load-use stall performance counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  5  ID source 1 index.
- id_rs2  in  5  ID source 2 index.
- id_use_rs1  in  1  instruction in ID reads rs1.
- id_use_rs2  in  1  instruction in ID reads rs2.
- ex_valid  in  1  EX holds a real instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_is_div  in  1  EX instruction is a div/rem op.
- ex_rf_waddr  in  5  EX destination register.
- mem1_valid  in  1  MEM1 holds a real instruction.
- mem1_is_load  in  1  MEM1 instruction is a load.
- mem1_rf_waddr  in  5  MEM1 destination register.
- trap_req  in  1  WB requests a redirect (exception/xret); single-cycle pulse.
- stall  out  STALL_W  per-stage hold vector.
- flush  out  1  clear all stage registers this cycle.
- div_busy  out  1  divider occupying EX.
- lu_stall_cnt  out  CNT_W  count of cycles stalled by load-use.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, div counter=0, lu_stall_cnt=0. Outputs are driven from registered state plus current inputs, so with reset asserted and quiescent inputs: stall=0, flush=0, div_busy=0.
- Stall vector is always monotonic: stall[k]=1 implies stall[j]=1 for all j<k. stall[STALL_W-1:5] is always 0.
- A stage register inserts a bubble when stall[k]=1 and stall[k+1]=0.
- Load data becomes forwardable at the end of MEM2.
- Load-use hazard (combinational), named lu:
  - src_hit(x) = id_valid & ((id_use_rs1 & id_rs1!=0 & id_rs1==x) | (id_use_rs2 & id_rs2!=0 & id_rs2==x)).
  - lu = src_hit(ex_rf_waddr) & ex_valid & ex_is_load  |  src_hit(mem1_rf_waddr) & mem1_valid & mem1_is_load.
  - lu drives stall[3:0]=4'hF: ID holds its instruction and EX gets a bubble.
  - Load in EX costs 2 stall cycles; load in MEM1 costs 1.
- FSM states: IDLE, DIV_BUSY, DIV_REL.
  - IDLE → DIV_BUSY when ex_valid & ex_is_div & !trap_req; counter loads DIV_LAT-2.
  - In DIV_BUSY: stall[4:0]=5'h1F (EX holds, MEM1 bubble) and div_busy=1. The counter decrements each cycle; at counter==0 go to DIV_REL.
  - DIV_REL: lasts exactly 1 cycle, with div_busy=0 and stall[4]=0 so the divide advances. It does not re-trigger on the same op. Next state is IDLE.
  - Total EX occupancy for a divide is DIV_LAT cycles.
- Priority each cycle: trap_req > DIV_BUSY > lu.
  - trap_req=1: flush=1 and stall=0 in the same cycle; next state IDLE; counter cleared. This covers a trap mid-divide.
  - In DIV_BUSY, lu is masked for stall generation, since stall[3:0] is already set.
  - In IDLE or DIV_REL, lu applies normally.
- lu_stall_cnt increments by 1 on each cycle where lu=1, state≠DIV_BUSY and trap_req=0. It wraps modulo 2^CNT_W.
- Reset asserted mid-divide: the next cycle is IDLE with all outputs 0, regardless of other inputs.
- rd==x0 never creates a hazard.
- Simultaneous EX and MEM1 load hits are a single stall condition, not additive.

Decomposition:
- Shared package/define file: STALL_W, stage index constants (ST_PC=0 … ST_WB=7), and FSM state encoding (IDLE=2'd0, DIV_BUSY=2'd1, DIV_REL=2'd2).
- One sub-module: div_seq_fsm, containing the FSM, counter and div_busy. The load-use compare, priority mux and perf counter stay in the top level.

Test Plan:
- Load x5 in EX, ID reads rs1=5 → stall=8'h0F for 2 cycles, then 8'h00. lu_stall_cnt 0→2.
- Load x5 in MEM1 only, ID reads rs2=5 → stall=8'h0F for 1 cycle. With id_rs2=0 and a load to x0 → no stall.
- Div enters EX with DIV_LAT=34 → div_busy=1 and stall=8'h1F for 33 cycles. Then 1 DIV_REL cycle with stall=0 and no re-trigger. A back-to-back second div re-enters DIV_BUSY.
- trap_req pulses at cycle 10 of a divide → flush=1 and stall=0 that cycle. Next cycle IDLE, div_busy=0.
- Load-use hazard present during DIV_BUSY → stall stays 8'h1F and lu_stall_cnt does not increment. Reset asserted mid-divide → all outputs 0 next cycle.
- Preload lu_stall_cnt near the wrap by running 2^CNT_W-1 hazard cycles with CNT_W overridden to 4 → the counter goes 15→0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: stall vector width,
// stage indices and the divider sequencer state encoding.
package pipe_hazard_ctrl_pkg;

  localparam int STALL_W = 8;

  // Stage indices. Stall bit k holds the register feeding stage k+1.
  localparam int ST_PC   = 0;
  localparam int ST_IF1  = 1;
  localparam int ST_IF2  = 2;
  localparam int ST_ID   = 3;
  localparam int ST_EX   = 4;
  localparam int ST_MEM1 = 5;
  localparam int ST_MEM2 = 6;
  localparam int ST_WB   = 7;

  // Load-use holds PC..ID and bubbles EX; a divide also holds EX and bubbles MEM1.
  localparam logic [ST_EX:0] LU_HOLD  = 5'h0F;
  localparam logic [ST_EX:0] DIV_HOLD = 5'h1F;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_REL  = 2'd2
  } div_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_div_seq_fsm.sv
// Divider sequencer: keeps EX occupied for DIV_LAT cycles in total
// (DIV_LAT-1 busy cycles plus one release cycle). A trap abandons the divide.
module div_seq_fsm
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 34
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       trap_req,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int CW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(DIV_LAT - 2);

  div_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: release lasts one cycle and always returns to IDLE, so the
  // divide still sitting in EX during release cannot re-trigger itself.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (trap_req) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_nxt = DIV_BUSY;
            cnt_nxt   = LOAD_VAL;
          end
        end
        DIV_BUSY: begin
          if (cnt == '0) state_nxt = DIV_REL;
          else           cnt_nxt   = cnt - 1'b1;
        end
        DIV_REL: state_nxt = IDLE;
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign busy      = (state == DIV_BUSY);
  assign state_dbg = state;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler: load-use detection, divider sequencing,
// trap flush and a load-use stall performance counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 34,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic               ex_valid,
  input  logic               ex_is_load,
  input  logic               ex_is_div,
  input  logic [4:0]         ex_rf_waddr,
  input  logic               mem1_valid,
  input  logic               mem1_is_load,
  input  logic [4:0]         mem1_rf_waddr,
  input  logic               trap_req,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               div_busy,
  output logic [CNT_W-1:0]   lu_stall_cnt
);

  logic       fsm_busy;
  logic [1:0] fsm_state_dbg;
  logic       hit_ex, hit_mem1, lu;
  logic       lu_count;

  // Source match against one destination; x0 never matches.
  function automatic logic src_hit(input logic [4:0] x);
    return id_valid &&
           ((id_use_rs1 && (id_rs1 != 5'd0) && (id_rs1 == x)) ||
            (id_use_rs2 && (id_rs2 != 5'd0) && (id_rs2 == x)));
  endfunction

  // Load data is forwardable only after MEM2, so loads in EX or MEM1 stall ID.
  always_comb begin
    hit_ex   = src_hit(ex_rf_waddr) && ex_valid && ex_is_load;
    hit_mem1 = src_hit(mem1_rf_waddr) && mem1_valid && mem1_is_load;
    lu       = hit_ex || hit_mem1;
  end

  div_seq_fsm #(.DIV_LAT(DIV_LAT)) u_div_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (ex_valid && ex_is_div),
    .trap_req  (trap_req),
    .busy      (fsm_busy),
    .state_dbg (fsm_state_dbg)
  );

  // Priority mux: reset > trap > divide > load-use. Stall stays monotonic.
  always_comb begin
    stall    = '0;
    flush    = 1'b0;
    div_busy = fsm_busy && !rst;
    if (rst) begin
      stall = '0;
    end else if (trap_req) begin
      flush = 1'b1;
    end else if (fsm_busy) begin
      stall[ST_EX:ST_PC] = DIV_HOLD;
    end else if (lu) begin
      stall[ST_EX:ST_PC] = LU_HOLD;
    end
  end

  assign lu_count = lu && !fsm_busy && !trap_req;

  // Load-use stall cycle counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)           lu_stall_cnt <= '0;
    else if (lu_count) lu_stall_cnt <= lu_stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random stimulus,
// all compared cycle by cycle against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

  localparam int DIV_LAT = 34;
  localparam int CNT_W   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2;
  logic       ex_valid, ex_is_load, ex_is_div;
  logic [4:0] ex_rf_waddr;
  logic       mem1_valid, mem1_is_load;
  logic [4:0] mem1_rf_waddr;
  logic       trap_req;
  logic [7:0] stall;
  logic       flush, div_busy;
  logic [CNT_W-1:0] lu_stall_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state: remaining busy cycles, pending release, counter.
  int m_busy_left = 0;
  bit m_rel       = 0;
  int m_cnt       = 0;

  logic [31:0] exp_q[$];

  pipe_hazard_ctrl #(.DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_valid      (ex_valid),
    .ex_is_load    (ex_is_load),
    .ex_is_div     (ex_is_div),
    .ex_rf_waddr   (ex_rf_waddr),
    .mem1_valid    (mem1_valid),
    .mem1_is_load  (mem1_is_load),
    .mem1_rf_waddr (mem1_rf_waddr),
    .trap_req      (trap_req),
    .stall         (stall),
    .flush         (flush),
    .div_busy      (div_busy),
    .lu_stall_cnt  (lu_stall_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit src_hit(input logic [4:0] x);
    if (!id_valid) return 0;
    if (id_use_rs1 && id_rs1 != 0 && id_rs1 == x) return 1;
    if (id_use_rs2 && id_rs2 != 0 && id_rs2 == x) return 1;
    return 0;
  endfunction

  function automatic bit model_lu();
    return (ex_valid && ex_is_load && src_hit(ex_rf_waddr)) ||
           (mem1_valid && mem1_is_load && src_hit(mem1_rf_waddr));
  endfunction

  task automatic clear_in();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_valid = 0; ex_is_load = 0; ex_is_div = 0; ex_rf_waddr = 0;
    mem1_valid = 0; mem1_is_load = 0; mem1_rf_waddr = 0;
    trap_req = 0;
  endtask

  // Called at a negedge with inputs already applied: check this cycle's
  // outputs against the model, then advance model and DUT by one clock.
  task automatic tick();
    logic [7:0] e_stall;
    bit e_flush, e_busy, lu;
    #1;
    lu = model_lu();
    e_stall = 8'h00; e_flush = 0; e_busy = 0;
    if (!rst) begin
      e_busy = (m_busy_left > 0);
      if (trap_req)            e_flush = 1;
      else if (m_busy_left > 0) e_stall = 8'h1F;
      else if (lu)              e_stall = 8'h0F;
    end
    exp_q.push_back({23'd0, e_busy, e_stall});
    check("stall", {24'd0, stall}, {24'd0, e_stall});
    check("flush", {31'd0, flush}, {31'd0, e_flush});
    check("div_busy", {31'd0, div_busy}, {31'd0, e_busy});
    check("lu_cnt", {28'd0, lu_stall_cnt}, m_cnt);
    void'(exp_q.pop_front());
    @(posedge clk);
    if (rst) begin
      m_busy_left = 0; m_rel = 0; m_cnt = 0;
    end else begin
      if (lu && m_busy_left == 0 && !trap_req) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (trap_req) begin
        m_busy_left = 0; m_rel = 0;
      end else if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) m_rel = 1;
      end else if (m_rel) begin
        m_rel = 0;
      end else if (ex_valid && ex_is_div) begin
        m_busy_left = DIV_LAT - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    clear_in();
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    int saved;
    clear_in();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    m_busy_left = 0; m_rel = 0; m_cnt = 0;

    // Reset state
    do_reset();
    check("rst_stall", {24'd0, stall}, 0);
    check("rst_cnt", {28'd0, lu_stall_cnt}, 0);

    // Load x5 in EX, ID reads rs1=5: two stall cycles as the load moves on.
    id_valid = 1; id_use_rs1 = 1; id_rs1 = 5;
    ex_valid = 1; ex_is_load = 1; ex_rf_waddr = 5;
    #1 check("lu_ex_c1", {24'd0, stall}, 32'h0F);
    tick();
    ex_valid = 0; ex_is_load = 0;
    mem1_valid = 1; mem1_is_load = 1; mem1_rf_waddr = 5;
    #1 check("lu_ex_c2", {24'd0, stall}, 32'h0F);
    tick();
    mem1_valid = 0; mem1_is_load = 0;
    #1 check("lu_ex_c3", {24'd0, stall}, 32'h00);
    check("lu_cnt_2", {28'd0, lu_stall_cnt}, 2);
    tick();

    // Load x5 in MEM1 only, ID reads rs2=5: one stall cycle.
    clear_in();
    id_valid = 1; id_use_rs2 = 1; id_rs2 = 5;
    mem1_valid = 1; mem1_is_load = 1; mem1_rf_waddr = 5;
    #1 check("lu_mem1", {24'd0, stall}, 32'h0F);
    tick();
    // x0 never hazards.
    id_rs2 = 0; mem1_rf_waddr = 0;
    #1 check("lu_x0", {24'd0, stall}, 32'h00);
    tick();

    // Divide: 33 busy cycles, one release, then a back-to-back second divide.
    clear_in();
    ex_valid = 1; ex_is_div = 1;
    tick();
    for (int i = 0; i < DIV_LAT - 1; i++) begin
      check("div_busy_on", {31'd0, div_busy}, 1);
      check("div_stall", {24'd0, stall}, 32'h1F);
      tick();
    end
    check("div_rel_stall", {24'd0, stall}, 0);
    check("div_rel_busy", {31'd0, div_busy}, 0);
    tick();
    check("div_b2b_entry", {31'd0, div_busy}, 0);
    tick();
    check("div_b2b_busy", {31'd0, div_busy}, 1);

    // Trap at cycle 10 of the divide.
    for (int i = 0; i < 9; i++) tick();
    trap_req = 1;
    #1 check("trap_flush", {31'd0, flush}, 1);
    check("trap_stall", {24'd0, stall}, 0);
    tick();
    trap_req = 0; ex_is_div = 0; ex_valid = 0;
    #1 check("trap_after_busy", {31'd0, div_busy}, 0);
    tick();

    // Load-use during a divide: stall stays 1F and the counter holds.
    ex_valid = 1; ex_is_div = 1;
    tick();
    id_valid = 1; id_use_rs1 = 1; id_rs1 = 7;
    mem1_valid = 1; mem1_is_load = 1; mem1_rf_waddr = 7;
    saved = lu_stall_cnt;
    for (int i = 0; i < 4; i++) tick();
    check("div_lu_stall", {24'd0, stall}, 32'h1F);
    check("div_lu_cnt", {28'd0, lu_stall_cnt}, saved);

    // Reset mid-divide with hazard inputs still present.
    rst = 1;
    tick();
    check("rst_mid_stall", {24'd0, stall}, 0);
    check("rst_mid_busy", {31'd0, div_busy}, 0);
    check("rst_mid_flush", {31'd0, flush}, 0);
    rst = 0;
    clear_in();
    tick();

    // Counter wrap with CNT_W=4.
    do_reset();
    id_valid = 1; id_use_rs1 = 1; id_rs1 = 3;
    ex_valid = 1; ex_is_load = 1; ex_rf_waddr = 3;
    for (int i = 0; i < 15; i++) tick();
    check("wrap_15", {28'd0, lu_stall_cnt}, 15);
    tick();
    check("wrap_0", {28'd0, lu_stall_cnt}, 0);
    clear_in();

    // Random stimulus.
    for (int n = 0; n < 1500; n++) begin
      rst           = ($urandom_range(0, 99) == 0);
      id_valid      = $urandom_range(0, 1);
      id_use_rs1    = $urandom_range(0, 1);
      id_use_rs2    = $urandom_range(0, 1);
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      ex_valid      = $urandom_range(0, 1);
      ex_is_load    = $urandom_range(0, 1);
      ex_is_div     = ($urandom_range(0, 15) == 0);
      ex_rf_waddr   = 5'($urandom_range(0, 3));
      mem1_valid    = $urandom_range(0, 1);
      mem1_is_load  = $urandom_range(0, 1);
      mem1_rf_waddr = 5'($urandom_range(0, 3));
      trap_req      = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
